// File: rtl/lab1_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// lab1_sweep_ctrl
//
// Purpose:
//   Drives the 3-input combinational lab1 logic (A, B, C -> X) through all
//   eight input vectors. Each vector is held for DWELL clock cycles. X is
//   sampled SETTLE cycles after the vector is applied, and the samples build
//   an 8-bit truth table. When the sweep completes, the captured table is
//   compared with the expected table and the result is flagged on mismatch.
//
// Optional build macro:
//   GRAY_ORDER_EN - when defined, the vectors are visited in Gray-code order
//                   (000,001,011,010,110,111,101,100), so exactly one input
//                   toggles per advance. truth stays indexed by vector value.
//                   When undefined, the vectors are visited in binary order.
//
// Parameters:
//   DWELL   - cycles each vector is held (2..255)
//   SETTLE  - cycles after a vector is applied before X is sampled
//             (1 <= SETTLE <= DWELL-1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (only looked at in IDLE)
//   abort      in   terminate a sweep in progress
//   X          in   output of the lab1 logic
//   expected   in   expected truth table, bit i = X for {A,B,C}=i
//   A, B, C    out  registered drives to lab1 (A is the MSB of the vector)
//   vec_idx    out  current vector value {A,B,C}
//   busy       out  sweep in progress
//   done       out  one-cycle pulse on sweep completion
//   truth      out  captured truth table, bit i = sampled X for vector i
//   mismatch   out  truth != expected, valid from the done pulse onward
//   dbg_state  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Control protocol (single comment for the whole start/busy/done contract):
//   start is a level request, sampled only while the FSM is in IDLE and only
//   honoured when abort is low. busy is high for exactly 8*DWELL cycles of a
//   sweep that runs to completion. done pulses for one cycle as busy falls.
//   abort has priority over start and over the final advance; an aborted
//   sweep never pulses done. start is ignored in RUN and DONE, so holding it
//   high starts a new sweep only on the edge after DONE returns to IDLE.
// -----------------------------------------------------------------------------
module lab1_sweep_ctrl #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       X,
  input  logic [7:0] expected,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth,
  output logic       mismatch,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The cycle counter holds 0 during the first cycle of a vector, so at the
  // edge t0+k*DWELL+n it reads n-1. Comparing against SETTLE-1 therefore
  // samples X at edge t0+k*DWELL+SETTLE, and comparing against DWELL-1
  // advances the vector at edge t0+(k+1)*DWELL.
  localparam logic [7:0] CAP_CNT = 8'(SETTLE - 1);
  localparam logic [7:0] ADV_CNT = 8'(DWELL - 1);

  // Vector visited at step k of the sweep.
  function automatic logic [2:0] order(input logic [2:0] k);
`ifdef GRAY_ORDER_EN
    return k ^ {1'b0, k[2:1]};
`else
    return k;
`endif
  endfunction

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] truth_q, truth_d;
  logic       mismatch_q, mismatch_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      cnt_q      <= 8'd0;
      vec_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      truth_q    <= 8'h00;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      truth_q    <= truth_d;
      mismatch_q <= mismatch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    truth_d    = truth_q;
    mismatch_d = mismatch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_RUN;
          step_d     = 3'd0;
          cnt_d      = 8'd0;
          truth_d    = 8'h00;
          mismatch_d = 1'b0;
          busy_d     = 1'b1;
          vec_d      = order(3'd0);
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Partial truth and the cleared mismatch are left as they are.
          state_d = ST_IDLE;
          step_d  = 3'd0;
          cnt_d   = 8'd0;
          vec_d   = 3'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;

          if (cnt_q == CAP_CNT) begin
            truth_d[vec_q] = X;
          end

          if (cnt_q == ADV_CNT) begin
            if (step_q != 3'd7) begin
              step_d = step_q + 3'd1;
              cnt_d  = 8'd0;
              vec_d  = order(step_q + 3'd1);
            end else begin
              state_d = ST_DONE;
              step_d  = 3'd0;
              cnt_d   = 8'd0;
              vec_d   = 3'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              // Compare against truth_d so a capture landing on this same
              // edge is included in the final table.
              mismatch_d = (truth_d != expected);
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign A         = vec_q[2];
  assign B         = vec_q[1];
  assign C         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth     = truth_q;
  assign mismatch  = mismatch_q;
  assign dbg_state = state_q;

endmodule
